// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: frame-synchronous double
// buffering, leading-zero blanking, per-digit blink and a dead cycle between digits.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   codes_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [3:0]    CODE_BLANK = 4'hF;
    localparam logic [6:0]    SEG_OFF    = 7'b1111111;

    typedef logic [DIGITS-1:0][3:0] codes_t;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            4'd10:   glyph = 7'b0011100;  // degree
            4'd11:   glyph = 7'b0101111;  // r
            4'd12:   glyph = 7'b0001001;  // H
            4'd13:   glyph = 7'b1000110;  // C
            4'd14:   glyph = 7'b0001110;  // F
            default: glyph = SEG_OFF;
        endcase
    endfunction

    // Scan and blink state
    logic [DW-1:0]     div_q, div_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic              live_q, live_d;

    // Display buffers
    logic              pend_v_q, pend_v_d;
    codes_t            pend_codes_q, pend_codes_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
    codes_t            act_codes_q, act_codes_d;
    logic [DIGITS-1:0] act_dp_q, act_dp_d;

    // Registered output images
    logic [6:0]        seg_d;
    logic              dp_d;
    logic [DIGITS-1:0] an_d;

    logic              tick, boundary, show, hide, lead;
    logic [DIGITS-1:0] lz_blank;
    logic [3:0]        cur_code;

    assign tick     = (div_q == DIV_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        div_d        = tick ? '0 : div_q + 1'b1;
        idx_d        = idx_q;
        blink_d      = blink_q;
        phase_d      = phase_q;
        live_d       = live_q | tick;
        pend_v_d     = pend_v_q;
        pend_codes_d = pend_codes_q;
        pend_dp_d    = pend_dp_q;
        act_codes_d  = act_codes_q;
        act_dp_d     = act_dp_q;

        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        if (boundary) begin
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
            // A load landing on the boundary bypasses the pending stage.
            if (load) begin
                act_codes_d = codes_t'(codes_in);
                act_dp_d    = dp_in;
            end else if (pend_v_q) begin
                act_codes_d = pend_codes_q;
                act_dp_d    = pend_dp_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_codes_d = codes_t'(codes_in);
            pend_dp_d    = dp_in;
            pend_v_d     = 1'b1;
        end
    end

    // Outputs are decoded from next-state values so the dead cycle already
    // carries the incoming digit's segments.
    always_comb begin
        lead        = blank_lz;
        lz_blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead        = lead && (act_codes_d[i] == 4'd0);
            lz_blank[i] = lead;
        end

        cur_code = act_codes_d[idx_d];
        show     = en && live_d;
        hide     = phase_d && blink_mask[idx_d];

        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = '1;
        if (show) begin
            if (!hide && !lz_blank[idx_d]) seg_d = glyph(cur_code);
            if (!hide)                     dp_d  = ~act_dp_d[idx_d];
            if (!tick)                     an_d  = ~(DIGITS'(1) << idx_d);
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            blink_q      <= '0;
            phase_q      <= 1'b0;
            live_q       <= 1'b0;
            pend_v_q     <= 1'b0;
            // NOTE: the digit buffers are plain registers (not RAM), so they are
            // reset to blank; this keeps stale data off the display after reset.
            pend_codes_q <= {DIGITS{CODE_BLANK}};
            pend_dp_q    <= '0;
            act_codes_q  <= {DIGITS{CODE_BLANK}};
            act_dp_q     <= '0;
            seg          <= SEG_OFF;
            dp           <= 1'b1;
            an           <= '1;
            frame_done   <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            live_q       <= live_d;
            pend_v_q     <= pend_v_d;
            pend_codes_q <= pend_codes_d;
            pend_dp_q    <= pend_dp_d;
            act_codes_q  <= act_codes_d;
            act_dp_q     <= act_dp_d;
            seg          <= seg_d;
            dp           <= dp_d;
            an           <= an_d;
            frame_done   <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle slots, 2-frame blink):
// a vector table of loaded frames plus hand sequences for timing corner cases.
module tb_seg7_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SDEG = 7'b0011100, SR = 7'b0101111,
                           SH = 7'b0001001, SC = 7'b1000110, SF = 7'b0001110,
                           SB = 7'b1111111;

    typedef logic [3:0][6:0] segs_t;   // written left-to-right: digit 3 .. digit 0

    typedef struct {
        logic [15:0] codes;
        logic [3:0]  dpv;
        logic        lz;
        segs_t       s;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              load = 1'b0;
    logic [15:0]       codes_in = '0;
    logic [3:0]        dp_in = '0;
    logic              blank_lz = 1'b0;
    logic [3:0]        blink_mask = '0;
    logic [6:0]        seg;
    logic              dp;
    logic [3:0]        an;
    logic              frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ld_k0 = -1;
    int ld_k1 = -1;
    logic [15:0] ld_c0 = '0;
    logic [15:0] ld_c1 = '0;

    vec_t vecs [8];

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .codes_in(codes_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .blink_mask(blink_mask),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 3 * FRAME) begin
            step();
            n++;
        end
        check("frame_sync", 32'(frame_done), 32'd1);
    endtask

    task automatic load_and_sync(input logic [15:0] c, input logic [3:0] d);
        codes_in = c;
        dp_in    = d;
        load     = 1'b1;
        step();
        load     = 1'b0;
        wait_frame();
    endtask

    task automatic check_reset_outputs();
        check("rst_seg", 32'(seg), 32'(SB));
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_an", 32'(an), 32'hF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    // Starts on the first cycle of a frame (frame_done high). Frames past the first
    // expect the "new" image; en is dropped at en_lo and raised at en_hi.
    task automatic scan(input int ncyc, input segs_t so, input logic [3:0] dpo,
                        input segs_t sn, input logic [3:0] dpn,
                        input int en_lo, input int en_hi);
        for (int k = 0; k < ncyc; k++) begin
            int         slot;
            int         ph;
            logic       on;
            logic       hide;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            slot = (k % FRAME) / SCAN_DIV;
            ph   = k % SCAN_DIV;
            on   = !(k > en_lo && k <= en_hi);
            hide = blink_mask[slot] && (((cyc / FRAME) / BLINK_FRAMES) % 2 == 1);
            ea   = 4'b1111;
            if (on && ph != 0) ea[slot] = 1'b0;
            es   = (!on || hide) ? SB : ((k >= FRAME) ? sn[slot] : so[slot]);
            ed   = (!on || hide) ? 1'b1 : ~((k >= FRAME) ? dpn[slot] : dpo[slot]);
            check("an", 32'(an), 32'(ea));
            check("seg", 32'(seg), 32'(es));
            check("dp", 32'(dp), 32'(ed));
            check("frame_done", 32'(frame_done), 32'(k % FRAME == 0));
            if (k == en_lo) en = 1'b0;
            if (k == en_hi) en = 1'b1;
            load = (k == ld_k0) || (k == ld_k1);
            if (k == ld_k1)      codes_in = ld_c1;
            else if (k == ld_k0) codes_in = ld_c0;
            step();
        end
        load  = 1'b0;
        ld_k0 = -1;
        ld_k1 = -1;
    endtask

    initial begin
        vecs[0] = '{codes: 16'h1234, dpv: 4'b0000, lz: 1'b0, s: {S1, S2, S3, S4}};
        vecs[1] = '{codes: 16'h00C5, dpv: 4'b0000, lz: 1'b1, s: {SB, SB, SH, S5}};
        vecs[2] = '{codes: 16'h0000, dpv: 4'b0000, lz: 1'b1, s: {SB, SB, SB, S0}};
        vecs[3] = '{codes: 16'h0000, dpv: 4'b0101, lz: 1'b0, s: {S0, S0, S0, S0}};
        vecs[4] = '{codes: 16'hABEF, dpv: 4'b1000, lz: 1'b1, s: {SDEG, SR, SF, SB}};
        vecs[5] = '{codes: 16'h0F00, dpv: 4'b0000, lz: 1'b1, s: {SB, SB, S0, S0}};
        vecs[6] = '{codes: 16'h6789, dpv: 4'b0010, lz: 1'b0, s: {S6, S7, S8, S9}};
        vecs[7] = '{codes: 16'h0D00, dpv: 4'b1001, lz: 1'b1, s: {SB, SC, S0, S0}};

        // Reset, then dark until the first tick; first lit digit is digit 1.
        rst = 1'b1;
        step();
        step();
        check_reset_outputs();
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < SCAN_DIV + 1; c++) begin
            check("an_before_first_tick", 32'(an), 32'hF);
            step();
        end
        check("an_first_lit", 32'(an), 32'b1101);
        check("seg_first_lit", 32'(seg), 32'(SB));

        foreach (vecs[i]) begin
            blank_lz = vecs[i].lz;
            load_and_sync(vecs[i].codes, vecs[i].dpv);
            scan(FRAME, vecs[i].s, vecs[i].dpv, vecs[i].s, vecs[i].dpv, -1, -1);
        end

        // Mid-frame load at idx=1 only shows from the next frame.
        blank_lz = 1'b0;
        load_and_sync(16'h1234, 4'b0000);
        ld_k0 = 5;
        ld_c0 = 16'h1111;
        scan(2 * FRAME, {S1, S2, S3, S4}, 4'b0, {S1, S1, S1, S1}, 4'b0, -1, -1);

        // Load on the boundary cycle is applied at that same boundary.
        ld_k0 = FRAME - 1;
        ld_c0 = 16'h2222;
        scan(2 * FRAME, {S1, S1, S1, S1}, 4'b0, {S2, S2, S2, S2}, 4'b0, -1, -1);

        // Two loads in one frame: the later one wins.
        ld_k0 = 2;
        ld_c0 = 16'h5555;
        ld_k1 = 9;
        ld_c1 = 16'h7777;
        scan(2 * FRAME, {S2, S2, S2, S2}, 4'b0, {S7, S7, S7, S7}, 4'b0, -1, -1);

        // Blink digit 0 across four frames (two visible, two hidden).
        blink_mask = 4'b0001;
        step();
        wait_frame();
        scan(4 * FRAME, {S7, S7, S7, S7}, 4'b0, {S7, S7, S7, S7}, 4'b0, -1, -1);
        blink_mask = 4'b0000;
        step();
        wait_frame();

        // Display disabled for one frame, then resumes mid-slot with no dead time.
        scan(FRAME + 5, {S7, S7, S7, S7}, 4'b0, {S7, S7, S7, S7}, 4'b0, 2, FRAME + 2);

        // Reset in slot 2 with a load pending: the pending data must never show.
        wait_frame();
        codes_in = 16'h8888;
        load     = 1'b1;
        step();
        load     = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        check_reset_outputs();
        rst = 1'b0;
        cyc = 0;
        wait_frame();
        scan(2 * FRAME, {SB, SB, SB, SB}, 4'b0, {SB, SB, SB, SB}, 4'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment displays, the parametrised successor of the single-digit BCD/glyph decoder. Takes DIGITS packed 4-bit glyph codes and scans them one digit at a time onto a shared active-low segment bus with per-digit active-low anode enables. Adds frame-synchronous double-buffered loading, leading-zero blanking, per-digit blinking and an anti-ghosting dead cycle. It sits between the sensor/readout logic and the board display pins.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (≥ 4).
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥ 1).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; 0 forces all outputs off while counters keep running.
- load  in  1  single-cycle strobe capturing codes_in/dp_in into the pending buffer.
- codes_in  in  4*DIGITS  glyph codes; digit i = bits [4i+3:4i], digit 0 is the rightmost/least significant.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = blank leading zeros.
- blink_mask  in  DIGITS  1 = digit blinks.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  anode enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Glyph map (active-low): 0..9 decimal digits (0=1000000 … 9=0010000), 10=degree 0011100, 11=r 0101111, 12=H 0001001, 13=C 1000110, 14=F 0001110, 15=blank 1111111.
- Slot counter div counts 0..SCAN_DIV-1 and wraps; tick = (div == SCAN_DIV-1).
- Digit index idx advances on tick, DIGITS-1 wraps to 0. Frame boundary = tick with idx == DIGITS-1; frame_done pulses that cycle.
- Buffering: load captures codes_in/dp_in into pending and sets pend_v. At a frame boundary with pend_v=1, pending is copied to active and pend_v cleared. If load coincides with a boundary, the load data goes straight to active and pend_v is cleared. A load mid-frame never alters the digits currently scanning. Back-to-back loads inside one frame: last one wins.
- Leading-zero blanking (blank_lz=1): scanning from digit DIGITS-1 downward, every code-0 digit before the first nonzero code displays blank; digit 0 is never blanked. Its dp still follows dp_in. Blank code 15 counts as nonzero for this purpose.
- Blink: blink counter counts frames 0..BLINK_FRAMES-1; on wrap, phase toggles. While phase=1, digits with blink_mask set show seg=1111111, dp=1, and their anode stays enabled.
- en=0: seg=1111111, dp=1, an=all ones; div, idx, blink and buffers keep operating.

## Timing
- Reset (1 cycle suffices): div=0, idx=0, blink count=0, phase=0, pend_v=0, active and pending codes=15 (blank), dp buffers=0; outputs seg=1111111, dp=1, an=all ones, frame_done=0.
- All outputs are registered. Cycle after a tick: an=all ones (dead cycle); seg/dp already carry the new digit. The following cycle, an[idx] goes low and holds until the next tick's dead cycle.
- Slot = SCAN_DIV cycles, digit lit SCAN_DIV-1 of them; frame = DIGITS*SCAN_DIV cycles.
- Load-to-display latency: from load until the next frame boundary, plus 2 cycles before digit 0 is lit with the new data.
- rst mid-frame wins over every other input, including load; pending data is discarded.
- After rst is released, the first tick occurs SCAN_DIV cycles later. an stays all ones until then.

## Test plan
- DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2. Reset, then load codes 0x1234 → after the next boundary, an cycles 1110→1101→1011→0111 showing 4,3,2,1 (seg 0011001, 0110000, 0100100, 1111001), an=1111 for exactly 1 cycle per slot, frame_done every 16 cycles.
- Load 0x00C5 with blank_lz=1 → digits 3,2 blank (1111111), digit 1=H 0001001, digit 0=5. Load 0x0000 → only digit 0 shows 0 (1000000).
- Load 0x1111 mid-frame at idx=1 → remaining slots in that frame still show old data; new data appears from the next frame. Load issued on the boundary cycle → applied that same boundary.
- blink_mask=0001 → digit 0 segments blank in frames 2-3, 6-7, …, visible in frames 0-1, 4-5; other digits unaffected.
- Assert rst during slot 2 with a pending load → next cycle all outputs at reset values, pend_v=0; no stale digit appears afterward.
- en=0 for one frame → an=1111, seg=1111111 throughout; frame_done still pulses. Re-enable → scanning resumes at the current idx with no extra dead time.
